regfile_read_port: RTL
======================

// Module: regfile_read_port
// PURPOSE
//  Read-side controller for the 8x8 register file: accepts read requests (single or burst)
//  over a valid/ready handshake, drives the file's read address, captures the selected
//  register and returns it over a valid/ready response channel. Sits between the
//  register-file array (flop-based, write-enabled words) and any consumer (ALU, debug dump).
// PARAMETERS
//  WIDTH  8  data bits per register
//  DEPTH  8  number of registers (power of two)
//  AW     3  address width, = log2(DEPTH)
// PORTS
//  clk        in   1      rising-edge clock
//  reset_n    in   1      asynchronous active-low reset
//  req_valid  in   1      request present
//  req_ready  out  1      request accepted when req_valid & req_ready
//  req_addr   in   AW     first register to read
//  req_len    in   AW     beats minus one (0 = 1 beat, DEPTH-1 = DEPTH beats)
//  rf_raddr   out  AW     read address to register-file output mux
//  rf_rdata   in   WIDTH  combinational read data for rf_raddr
//  rsp_valid  out  1      response beat present
//  rsp_ready  in   1      consumer takes beat when rsp_valid & rsp_ready
//  rsp_data   out  WIDTH  register contents
//  rsp_addr   out  AW     address the beat was read from
//  rsp_last   out  1      final beat of the burst
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE; req_ready=1; rsp_valid=0; rsp_last=0;
//    rsp_data=0; rsp_addr=0; rf_raddr=0; pointer and beat counter=0. Reset mid-burst
//    abandons the burst immediately; no further beats after release.
//  - FSM, three states:
//    IDLE: req_ready=1. On accept: ptr<=req_addr, remaining<=req_len -> READ.
//    READ: req_ready=0; rf_raddr=ptr; at clock edge rsp_data<=rf_rdata, rsp_addr<=ptr,
//          rsp_last<=(remaining==0), rsp_valid<=1 -> RESP.
//    RESP: rsp_valid=1, outputs held stable until rsp_ready. On handshake:
//          last beat -> IDLE (rsp_valid<=0); else ptr<=ptr+1 mod DEPTH,
//          remaining<=remaining-1 -> READ (rsp_valid<=0).
//  - Latency: accept edge -> rsp_valid high 2 edges later. Burst throughput: one beat
//    per 2 cycles when rsp_ready held high.
//  - Address wrap: ptr increments modulo DEPTH (addr 6, len 3 -> 6,7,0,1).
//  - rf_raddr is registered pointer, constant outside READ (holds last value).
//  - Read/write collision: a write landing on the same edge as READ capture returns the
//    pre-write value (file is flop-based); captured rsp_data never changes while held.
//  - No new request is accepted until the last beat's handshake completes (req_ready=0
//    in READ and RESP); req_* ignored outside IDLE.
//  - rsp_valid, once high, never drops without a handshake (except reset).
// STRUCTURE
//  - Shared package: state encoding (IDLE/READ/RESP), WIDTH/DEPTH/AW defaults.
//  - Single module, no sub-modules; the file's output mux stays in the file itself.
// TESTING
//  1. Reset: reset_n=0 mid-RESP -> rsp_valid=0, req_ready=1 immediately, no beat after.
//  2. Single read: reg3=8'hA5, req addr=3 len=0, rsp_ready=1 -> rsp_valid 2 cycles later,
//     data=A5, addr=3, last=1; back to IDLE with req_ready=1.
//  3. Wrapping burst: regs k=8'h10+k, req addr=6 len=3 -> beats 16,17,10,11 on addrs
//     6,7,0,1; last only on 4th beat.
//  4. Backpressure: rsp_ready=0 for 5 cycles during a beat -> data/addr/last stable,
//     rf_raddr unchanged, next beat only after handshake.
//  5. Collision: write reg2=8'hFF on same edge as READ of reg2 (old 8'h22) -> rsp_data=22;
//     a following read of reg2 returns FF.
//  6. Request while busy: req_valid asserted during burst -> not accepted (req_ready=0);
//     accepted on first IDLE cycle after last handshake.

Source files
------------

// File: rtl/regfile_read_port_pkg.sv
// Shared types and default geometry for the register-file read port.
package regfile_read_port_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 8;
  localparam int AW_DEF    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } rd_state_t;
endpackage

// File: rtl/regfile_read_port.sv
// Read-side controller: takes single/burst read requests, drives the file's
// read address, captures one register per beat and returns it over valid/ready.
module regfile_read_port
  import regfile_read_port_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_addr,
  input  logic [AW-1:0]    req_len,
  output logic [AW-1:0]    rf_raddr,
  input  logic [WIDTH-1:0] rf_rdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [AW-1:0]    rsp_addr,
  output logic             rsp_last
);

  rd_state_t     state, state_next;
  logic [AW-1:0] ptr;
  logic [AW-1:0] remaining;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = READ;
      READ:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = rsp_last ? IDLE : READ;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rf_raddr  = ptr;
  end

  // Pointer only moves on accept or on a non-final handshake, so the read
  // address stays put while a beat is being held under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr       <= '0;
      remaining <= '0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          ptr       <= req_addr;
          remaining <= req_len;
        end
        READ: begin
          rsp_data <= rf_rdata;
          rsp_addr <= ptr;
          rsp_last <= (remaining == '0);
        end
        RESP: if (rsp_ready && !rsp_last) begin
          ptr       <= ptr + AW'(1);
          remaining <= remaining - AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
